// File: rtl/seg_display_driver_pkg.sv
// Shared constants and buffer type for the multiplexed 7-segment display driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;
  localparam logic [6:0] BLANK_SEG  = 7'b1111111;
  localparam logic [3:0] ALL_OFF_AN = 4'b1111;

  // Indexed by hex digit; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
  } disp_buf_t;
endpackage

// File: rtl/seg_display_driver_if.sv
// Load strobe / data in, multiplexed display pins out.
interface seg_display_driver_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  modport master (output load, value, dp, input an, seg, dp_n, frame_done);
  modport slave  (input load, value, dp, output an, seg, dp_n, frame_done);
endinterface

// File: rtl/seg_display_driver_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);
  assign seg_n = SEG_LUT[hex];
endmodule

// File: rtl/seg_display_driver.sv
// Time-multiplexed 4-digit hex display with frame-synchronous double buffering
// and optional leading-zero blanking.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_display_driver_if.slave  bus
);
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  disp_buf_t        shadow_q, shadow_d, active_q, active_d;
  logic             pending_q, pending_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpn_q, dpn_d;

  logic       tick, frame, blank;
  logic [3:0] cur_hex;
  logic [6:0] cur_seg;
  disp_buf_t  in_buf;

  assign in_buf  = {bus.value, bus.dp};
  assign tick    = &div_q;
  assign frame   = tick && (idx_q == 2'd3);
  assign cur_hex = active_q.value[{idx_q, 2'b00} +: 4];
  // A digit is a leading zero when it and everything above it are zero.
  assign blank   = BLANK_LZ && (idx_q != 2'd0) &&
                   ((active_q.value >> {idx_q, 2'b00}) == 16'd0);

  hex_to_seg u_dec (.hex(cur_hex), .seg_n(cur_seg));

  always_comb begin
    div_d     = div_q + DIV_W'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (bus.load) begin
      shadow_d  = in_buf;
      pending_d = 1'b1;
    end
    // Active buffer only changes on the frame edge, so a frame never tears.
    if (frame) begin
      if (bus.load) begin
        active_d  = in_buf;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
    an_d  = blank ? ALL_OFF_AN : ~(4'b0001 << idx_q);
    seg_d = blank ? BLANK_SEG : cur_seg;
    dpn_d = blank ? 1'b1 : ~active_q.dp[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= ALL_OFF_AN;
      seg_q     <= BLANK_SEG;
      dpn_q     <= 1'b1;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dpn_q     <= dpn_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dpn_q;
  assign bus.frame_done = frame;
endmodule

// File: tb/tb_seg_display_driver.sv
// Randomized and directed bench for seg_display_driver against a cycle-count
// based reference model of the display schedule and double buffering.
module tb_seg_display_driver;
  localparam int DIV_W    = 2;
  localparam bit BLANK_LZ = 1'b1;
  localparam int P        = 1 << DIV_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  seg_display_driver_if bus ();

  seg_display_driver #(.DIV_W(DIV_W), .BLANK_LZ(BLANK_LZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: n counts cycles since reset release.
  int          n;
  logic [15:0] act_v, sh_v;
  logic [3:0]  act_dp, sh_dp;
  logic        pend;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dpn, exp_fd, obs_fd;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic is_frame(input int k);
    return (k % P == P - 1) && ((k / P) % 4 == 3);
  endfunction

  task automatic model_reset();
    n = 0; act_v = '0; act_dp = '0; sh_v = '0; sh_dp = '0; pend = 1'b0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dpn = 1'b1; exp_fd = 1'b0; obs_fd = 1'b0;
  endtask

  // One clock cycle: entered and left at the falling edge.
  task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] d);
    int          dig;
    logic [15:0] rest;
    bus.load = ld; bus.value = v; bus.dp = d;
    #1;
    obs_fd = bus.frame_done;
    exp_fd = is_frame(n);
    dig    = (n / P) % 4;
    rest   = act_v >> (4 * dig);
    if (BLANK_LZ && dig != 0 && rest == 16'd0) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dpn = 1'b1;
    end else begin
      exp_an  = ~(4'b0001 << dig);
      exp_seg = hex_tab[rest[3:0]];
      exp_dpn = ~act_dp[dig];
    end
    if (ld) begin sh_v = v; sh_dp = d; pend = 1'b1; end
    if (is_frame(n)) begin
      if (ld) begin act_v = v; act_dp = d; pend = 1'b0; end
      else if (pend) begin act_v = sh_v; act_dp = sh_dp; pend = 1'b0; end
    end
    n++;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 16'h0, 4'h0);
  endtask

  // Runs up to and including the next frame-boundary cycle.
  task automatic pass_frame();
    for (int i = 0; i < 4 * P && !is_frame(n); i++) cyc(1'b0, 16'h0, 4'h0);
    cyc(1'b0, 16'h0, 4'h0);
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.value = '0; bus.dp = '0;
    #1 rst = 1'b1;
    #1;
    checks += 4;
    if (bus.an !== 4'hF)        begin failures++; $display("FAIL reset_an got=%b want=1111", bus.an); end
    if (bus.seg !== 7'h7F)      begin failures++; $display("FAIL reset_seg got=%b want=1111111", bus.seg); end
    if (bus.dp_n !== 1'b1)      begin failures++; $display("FAIL reset_dpn got=%b want=1", bus.dp_n); end
    if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b want=0", bus.frame_done); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.an !== 4'hF) begin failures++; $display("FAIL release_an got=%b want=1111", bus.an); end
    cyc(1'b0, 16'h0, 4'h0);
    checks += 3;
    if (bus.an !== 4'b1110)    begin failures++; $display("FAIL first_an got=%b want=1110", bus.an); end
    if (bus.seg !== 7'h40)     begin failures++; $display("FAIL first_seg got=%b want=1000000", bus.seg); end
    if (bus.dp_n !== 1'b1)     begin failures++; $display("FAIL first_dpn got=%b want=1", bus.dp_n); end
    // First tick lands 2^DIV_W cycles after release; digit 1 (blank) follows.
    idle(P - 1);
    checks++;
    if (bus.an !== 4'b1110) begin failures++; $display("FAIL pre_tick_an got=%b want=1110", bus.an); end
    cyc(1'b0, 16'h0, 4'h0);
    checks++;
    if (bus.an !== 4'hF) begin failures++; $display("FAIL post_tick_an got=%b want=1111", bus.an); end
  endtask

  task automatic test_hex_dp();
    cyc(1'b1, 16'h12AF, 4'b0001);
    pass_frame();
    checks++;
    if (obs_fd !== 1'b1) begin failures++; $display("FAIL hex_fd got=%b want=1", obs_fd); end
    cyc(1'b0, 16'h0, 4'h0);
    checks += 3;
    if (bus.an !== 4'b1110)   begin failures++; $display("FAIL hex_d0_an got=%b want=1110", bus.an); end
    if (bus.seg !== 7'h0E)    begin failures++; $display("FAIL hex_d0_seg got=%b want=0001110", bus.seg); end
    if (bus.dp_n !== 1'b0)    begin failures++; $display("FAIL hex_d0_dpn got=%b want=0", bus.dp_n); end
    idle(3 * P);
    checks += 2;
    if (bus.an !== 4'b0111)   begin failures++; $display("FAIL hex_d3_an got=%b want=0111", bus.an); end
    if (bus.seg !== 7'h79)    begin failures++; $display("FAIL hex_d3_seg got=%b want=1111001", bus.seg); end
  endtask

  task automatic test_lz();
    cyc(1'b1, 16'h0050, 4'b0000);
    pass_frame();
    cyc(1'b0, 16'h0, 4'h0);
    checks += 2;
    if (bus.an !== 4'b1110) begin failures++; $display("FAIL lz50_d0_an got=%b want=1110", bus.an); end
    if (bus.seg !== 7'h40)  begin failures++; $display("FAIL lz50_d0_seg got=%b want=1000000", bus.seg); end
    idle(P);
    checks += 2;
    if (bus.an !== 4'b1101) begin failures++; $display("FAIL lz50_d1_an got=%b want=1101", bus.an); end
    if (bus.seg !== 7'h12)  begin failures++; $display("FAIL lz50_d1_seg got=%b want=0010010", bus.seg); end
    idle(P);
    checks++;
    if (bus.an !== 4'hF) begin failures++; $display("FAIL lz50_d2_an got=%b want=1111", bus.an); end
    idle(P);
    checks++;
    if (bus.an !== 4'hF) begin failures++; $display("FAIL lz50_d3_an got=%b want=1111", bus.an); end

    cyc(1'b1, 16'h0000, 4'b1111);
    pass_frame();
    cyc(1'b0, 16'h0, 4'h0);
    checks += 3;
    if (bus.an !== 4'b1110) begin failures++; $display("FAIL lz0_d0_an got=%b want=1110", bus.an); end
    if (bus.seg !== 7'h40)  begin failures++; $display("FAIL lz0_d0_seg got=%b want=1000000", bus.seg); end
    if (bus.dp_n !== 1'b0)  begin failures++; $display("FAIL lz0_d0_dpn got=%b want=0", bus.dp_n); end
    for (int d = 1; d < 4; d++) begin
      idle(P);
      checks += 3;
      if (bus.an !== 4'hF)   begin failures++; $display("FAIL lz0_d%0d_an got=%b want=1111", d, bus.an); end
      if (bus.seg !== 7'h7F) begin failures++; $display("FAIL lz0_d%0d_seg got=%b want=1111111", d, bus.seg); end
      if (bus.dp_n !== 1'b1) begin failures++; $display("FAIL lz0_d%0d_dpn got=%b want=1", d, bus.dp_n); end
    end
  endtask

  task automatic test_last_load_wins();
    // Active holds 0000 with all dp requested.
    pass_frame();
    cyc(1'b1, 16'h1111, 4'b0000);
    checks += 2;
    if (bus.seg !== 7'h40) begin failures++; $display("FAIL llw_cur_seg got=%b want=1000000", bus.seg); end
    if (bus.dp_n !== 1'b0) begin failures++; $display("FAIL llw_cur_dpn got=%b want=0", bus.dp_n); end
    cyc(1'b1, 16'h2222, 4'b0000);
    idle(P);
    checks++;
    if (bus.an !== 4'hF) begin failures++; $display("FAIL llw_cur_d1_an got=%b want=1111", bus.an); end
    pass_frame();
    cyc(1'b0, 16'h0, 4'h0);
    checks += 2;
    if (bus.seg !== 7'h24) begin failures++; $display("FAIL llw_d0_seg got=%b want=0100100", bus.seg); end
    if (bus.dp_n !== 1'b1) begin failures++; $display("FAIL llw_d0_dpn got=%b want=1", bus.dp_n); end
    idle(P);
    checks += 2;
    if (bus.an !== 4'b1101) begin failures++; $display("FAIL llw_d1_an got=%b want=1101", bus.an); end
    if (bus.seg !== 7'h24)  begin failures++; $display("FAIL llw_d1_seg got=%b want=0100100", bus.seg); end
  endtask

  task automatic test_load_at_boundary();
    for (int i = 0; i < 4 * P && !is_frame(n); i++) cyc(1'b0, 16'h0, 4'h0);
    cyc(1'b1, 16'h3333, 4'b0000);
    checks++;
    if (obs_fd !== 1'b1) begin failures++; $display("FAIL lab_fd got=%b want=1", obs_fd); end
    cyc(1'b0, 16'h0, 4'h0);
    checks += 2;
    if (bus.an !== 4'b1110) begin failures++; $display("FAIL lab_d0_an got=%b want=1110", bus.an); end
    if (bus.seg !== 7'h30)  begin failures++; $display("FAIL lab_d0_seg got=%b want=0110000", bus.seg); end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 16'hFFFF, 4'hF);
    pass_frame();
    cyc(1'b0, 16'h0, 4'h0);
    cyc(1'b1, 16'h4444, 4'h0);
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (bus.an !== 4'hF)         begin failures++; $display("FAIL ar_an got=%b want=1111", bus.an); end
    if (bus.seg !== 7'h7F)       begin failures++; $display("FAIL ar_seg got=%b want=1111111", bus.seg); end
    if (bus.dp_n !== 1'b1)       begin failures++; $display("FAIL ar_dpn got=%b want=1", bus.dp_n); end
    if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL ar_fd got=%b want=0", bus.frame_done); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(1'b0, 16'h0, 4'h0);
    checks += 2;
    if (bus.seg !== 7'h40) begin failures++; $display("FAIL ar_active_seg got=%b want=1000000", bus.seg); end
    if (bus.dp_n !== 1'b1) begin failures++; $display("FAIL ar_active_dpn got=%b want=1", bus.dp_n); end
    pass_frame();
    cyc(1'b0, 16'h0, 4'h0);
    checks++;
    if (bus.seg !== 7'h40) begin failures++; $display("FAIL ar_pending_seg got=%b want=1000000", bus.seg); end
  endtask

  task automatic test_random();
    logic        ld;
    logic [15:0] v;
    logic [3:0]  d;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom % 5 == 0);
      v  = 16'($urandom);
      d  = 4'($urandom);
      case ($urandom % 4)
        0: v = v & 16'h000F;
        1: v = v & 16'h00FF;
        2: v = v & 16'h0FFF;
        default: ;
      endcase
      cyc(ld, v, d);
      checks += 5;
      if (bus.an !== exp_an)   begin failures++; $display("FAIL rnd_an n=%0d got=%b want=%b", n, bus.an, exp_an); end
      if (bus.seg !== exp_seg) begin failures++; $display("FAIL rnd_seg n=%0d got=%b want=%b", n, bus.seg, exp_seg); end
      if (bus.dp_n !== exp_dpn) begin failures++; $display("FAIL rnd_dpn n=%0d got=%b want=%b", n, bus.dp_n, exp_dpn); end
      if (obs_fd !== exp_fd)   begin failures++; $display("FAIL rnd_fd n=%0d got=%b want=%b", n, obs_fd, exp_fd); end
      if ($countones(~bus.an) > 1) begin failures++; $display("FAIL rnd_onehot n=%0d got=%b want<=1 low", n, bus.an); end
    end
  endtask

  initial begin
    test_reset();
    test_hex_dp();
    test_lz();
    test_last_load_wins();
    test_load_at_boundary();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
